shift_arbiter: RTL and testbench
================================

# shift_arbiter

Sequencing controller that shares one 4-bit arithmetic right shifter (`arithmetic_right_shifter`, shamt 0–3 per pass) between two requesters and extends its range to shift amounts 0–15.
- Arbitrates between the requesters round-robin.
- Performs the shift iteratively, up to 3 bit positions per cycle.
- Returns the result with a requester ID over a valid/ready response port.
- Sits between execute-stage shift consumers and the shared shifter datapath.

## Interface
- Parameters: none. Widths are fixed: 4-bit data, 4-bit shift amount, 2 requesters.
- `clk` input 1 – the single clock; all state updates on its rising edge.
- `reset` input 1 – synchronous, active-high.
- `req_valid` input 2 – request valid, one bit per requester.
- `req_a` input 8 – operand: [3:0] for requester 0, [7:4] for requester 1.
- `req_shamt` input 8 – shift amount 0–15: [3:0] for requester 0, [7:4] for requester 1.
- `req_ready` output 2 – one-hot or zero; the grant / accept indication.
- `resp_valid` output 1 – result valid.
- `resp_data` output 4 – shifted result.
- `resp_id` output 1 – requester that owns `resp_data`.
- `resp_ready` input 1 – consumer accepts the result.
- `busy` output 1 – high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: `req_ready` is driven by the arbiter.
  - SHIFT: iterating.
  - DONE: result presented.
- Arbitration is combinational and active in IDLE only.
  - If exactly one request is valid, that requester gets `req_ready`.
  - If both are valid, the requester not equal to `last_grant` wins.
  - `req_ready` is never asserted outside IDLE.
- IDLE→SHIFT on `req_valid[i] & req_ready[i]`. On that edge:
  - `acc` ← `req_a[i]`
  - `rem` ← `req_shamt[i]`
  - `id` ← i
  - `last_grant` ← i
- SHIFT, every cycle:
  - `step` = min(`rem`, 3) (2 bits).
  - `acc` ← shifter(`acc`, `step`); `rem` ← `rem` − `step`.
  - When the new `rem` is 0, go to DONE.
  - Shamt 0 still spends one SHIFT cycle with step 0.
- Arithmetic: sign-fill from `acc[3]`; no early-out. Shifts ≥4 saturate naturally to 4'b0000 or 4'b1111.
- DONE: `resp_valid` = 1, `resp_data` = `acc`, `resp_id` = `id`.
  - All three are held stable while `resp_ready` = 0.
  - `resp_valid & resp_ready` → IDLE.
- Response handshake and new-request acceptance never occur on the same edge. The earliest next accept is the cycle after return to IDLE.
- Requests that are not granted are not queued; requesters hold `req_valid` until granted.
- Reset (at any state, including mid-SHIFT or DONE):
  - State → IDLE; the in-flight operation is discarded with no response.
  - `acc`, `rem`, `id` ← 0; `last_grant` ← 1, so requester 0 wins the first tie.
  - Outputs: `req_ready` reflects IDLE arbitration; `resp_valid` = 0, `resp_data` = 0, `resp_id` = 0, `busy` = 0.

## Timing
- Number of SHIFT cycles N = max(1, ceil(shamt/3)):
  - shamt 0 → 1; shamt 1–3 → 1; 4–6 → 2; 7–9 → 3; 10–12 → 4; 13–15 → 5.
- `resp_valid` rises N cycles after the accept edge.
- Throughput per requester, with `resp_ready` held high: one result every N+2 cycles (accept, N SHIFT, DONE).
- `req_ready` is combinational from `req_valid` and state. All other outputs are registered or decoded from state only.

## Structure
- Shared package/header `shift_arbiter_defs` holds:
  - state encodings `ST_IDLE`, `ST_SHIFT`, `ST_DONE` (2-bit);
  - `MAX_STEP` = 3;
  - widths `DATA_W` = 4 and `AMT_W` = 4.
- One sub-module instance: `arithmetic_right_shifter`, input `acc`, shamt `step`, output feeds the `acc` next-state.
- Arbiter, state machine and counters are local logic; no further sub-modules.

## Test plan
- Long shift: req0 A=4'b1000, shamt=5.
  - Steps 3 then 2; `resp_valid` 2 cycles after accept.
  - `resp_data` = 4'b1111, `resp_id` = 0.
- Shamt limits:
  - A=4'b0110, shamt=0 → 4'b0110 after 1 cycle.
  - A=4'b0111, shamt=15 → 4'b0000 after 5 cycles, `busy` high throughout.
- Tie from reset: both requests valid in the same cycle.
  - req0 (A=4'b1010, sh=1) is granted first → 4'b1101, id 0.
  - req1 (A=4'b0100, sh=2) is granted next → 4'b0001, id 1.
  - Grant order then alternates on repeated ties.
- Backpressure: `resp_ready` = 0 for 3 cycles in DONE.
  - `resp_valid`, `resp_data` and `resp_id` stay stable; `req_ready` stays 2'b00.
  - After `resp_ready` = 1: IDLE on the next edge, accept the cycle after.
- Reset mid-operation: assert `reset` during SHIFT of a shamt=12 request.
  - Next cycle: IDLE, `busy` = 0, `resp_valid` = 0.
  - No response is ever issued for the discarded request.
  - A subsequent tie grants requester 0.

Source files
------------

// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the shift arbiter: widths, per-pass step limit and FSM states.
package shift_arbiter_defs;

  localparam int unsigned DATA_W   = 4;
  localparam int unsigned AMT_W    = 4;
  localparam int unsigned MAX_STEP = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_arbiter_shifter.sv
// Shared 4-bit arithmetic right shifter, 0-3 positions per pass.
module arithmetic_right_shifter
  import shift_arbiter_defs::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [1:0]        shamt_i,
  output logic [DATA_W-1:0] y_o
);

  assign y_o = DATA_W'($signed(a_i) >>> shamt_i);

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter that runs 0-15 bit arithmetic right shifts for two requesters
// through one shared shifter, up to three positions per cycle.
module shift_arbiter
  import shift_arbiter_defs::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*AMT_W-1:0]  req_shamt,
  output logic [1:0]          req_ready,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_data,
  output logic                resp_id,
  input  logic                resp_ready,
  output logic                busy
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [AMT_W-1:0]    rem_q, rem_d;
  logic                id_q, id_d;
  logic                last_grant_q, last_grant_d;
  logic [1:0]          grant;
  logic [1:0]          step;
  logic [DATA_W-1:0]   shifted;

  always_comb begin
    unique case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign step = (rem_q > AMT_W'(MAX_STEP)) ? 2'(MAX_STEP) : rem_q[1:0];

  arithmetic_right_shifter u_shifter (
    .a_i     (acc_q),
    .shamt_i (step),
    .y_o     (shifted)
  );

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    rem_d        = rem_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    req_ready    = '0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = grant;
        if (|(req_valid & grant)) begin
          state_d      = ST_SHIFT;
          acc_d        = grant[1] ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
          rem_d        = grant[1] ? req_shamt[2*AMT_W-1:AMT_W] : req_shamt[AMT_W-1:0];
          id_d         = grant[1];
          last_grant_d = grant[1];
        end
      end
      ST_SHIFT: begin
        // shamt 0 still takes one pass with step 0
        acc_d = shifted;
        rem_d = rem_q - AMT_W'(step);
        if (rem_d == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      rem_q        <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      rem_q        <= rem_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign resp_valid = (state_q == ST_DONE);
  assign resp_data  = acc_q;
  assign resp_id    = id_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed plus randomized bench for shift_arbiter against an arithmetic reference model.
module tb_shift_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_valid;
  logic [7:0] req_a;
  logic [7:0] req_shamt;
  logic [1:0] req_ready;
  logic       resp_valid;
  logic [3:0] resp_data;
  logic       resp_id;
  logic       resp_ready;
  logic       busy;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int          model_last = 1;

  always #5 clk = ~clk;

  shift_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_shamt  (req_shamt),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_ready (resp_ready),
    .busy       (busy)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Floor division of the signed operand by 2^s, wrapped back to 4 bits.
  function automatic int ref_shift(input int a, input int s);
    int v;
    int p;
    v = (a >= 8) ? a - 16 : a;
    if (s >= 4) return (v < 0) ? 15 : 0;
    p = 1 << s;
    if (v < 0) v = (v - (p - 1)) / p;
    else       v = v / p;
    return v & 15;
  endfunction

  function automatic int ref_cycles(input int s);
    return (s == 0) ? 1 : (s + 2) / 3;
  endfunction

  // Issue a request pattern, check grant, latency, result and handshake.
  task automatic txn(input logic [1:0] mask, input int a0, input int s0,
                     input int a1, input int s1, input int bp);
    int win, a, s, cyc;
    int hold_d, hold_id;
    @(negedge clk);
    req_valid = mask;
    req_a     = {4'(a1), 4'(a0)};
    req_shamt = {4'(s1), 4'(s0)};
    resp_ready = (bp == 0);
    win = (mask == 2'b01) ? 0 : (mask == 2'b10) ? 1 : (model_last == 1 ? 0 : 1);
    #1;
    chk("grant", int'(req_ready), 1 << win);
    model_last = win;
    a = win ? a1 : a0;
    s = win ? s1 : s0;
    @(negedge clk);
    req_valid = 2'b00;
    cyc = 0;
    while (!resp_valid && cyc < 30) begin
      chk("busy_shift", int'(busy), 1);
      chk("ready_shift", int'(req_ready), 0);
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, ref_cycles(s));
    chk("resp_data", int'(resp_data), ref_shift(a, s));
    chk("resp_id", int'(resp_id), win);
    hold_d  = int'(resp_data);
    hold_id = int'(resp_id);
    for (int i = 0; i < bp; i++) begin
      req_valid = 2'b11;
      #1;
      chk("bp_ready", int'(req_ready), 0);
      @(negedge clk);
      chk("bp_valid", int'(resp_valid), 1);
      chk("bp_data", int'(resp_data), hold_d);
      chk("bp_id", int'(resp_id), hold_id);
    end
    req_valid  = 2'b00;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("idle_valid", int'(resp_valid), 0);
    chk("idle_busy", int'(busy), 0);
  endtask

  initial begin
    int cyc;
    reset = 1'b1; req_valid = '0; req_a = '0; req_shamt = '0; resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(resp_valid), 0);
    chk("rst_data", int'(resp_data), 0);
    chk("rst_id", int'(resp_id), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;

    txn(2'b11, 4'b1010, 1, 4'b0100, 2, 0);   // tie from reset: req0 first
    txn(2'b10, 0, 0, 4'b0100, 2, 0);
    txn(2'b11, 1, 3, 9, 4, 0);               // alternation on repeated ties
    txn(2'b11, 1, 3, 9, 4, 0);
    txn(2'b01, 4'b1000, 5, 0, 0, 0);         // long shift
    txn(2'b01, 4'b0110, 0, 0, 0, 0);         // shamt 0
    txn(2'b10, 0, 0, 4'b0111, 15, 0);        // shamt 15
    txn(2'b01, 4'b1001, 15, 0, 0, 0);
    txn(2'b01, 4'b1100, 2, 0, 0, 3);         // backpressure

    // Reset during SHIFT of a shamt=12 request
    @(negedge clk);
    req_valid = 2'b01; req_a = 8'h05; req_shamt = 8'h0C;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    chk("mid_busy", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_last = 1;
    chk("rr_busy", int'(busy), 0);
    chk("rr_valid", int'(resp_valid), 0);
    chk("rr_data", int'(resp_data), 0);
    chk("rr_id", int'(resp_id), 0);
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid) cyc++;
    end
    chk("no_resp_after_reset", cyc, 0);
    txn(2'b11, 3, 1, 12, 1, 0);

    for (int n = 0; n < 40; n++) begin
      txn(2'($urandom_range(1, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
